// File: rtl/scramble_sequencer.sv
// Shares the grid select/fire path between the player and an automatic scrambler that issues NUM_MOVES
// pseudo-random row/column fires per request; each move is 1+2*SETTLE_CYCLES+FIRE_WIDTH cycles.
module scramble_sequencer #(
   parameter int NUM_MOVES     = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int FIRE_WIDTH    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] rand_in,
   input  logic       user_nRow,
   input  logic [3:0] user_row_column,
   input  logic       user_fire,
   output logic       x_nRow,
   output logic [3:0] row_column,
   output logic       fire,
   output logic       busy,
   output logic       done,
   output logic [7:0] moves_done
);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, FIRE, GAP, DONE} state_t;

   localparam int PH_MAX = (SETTLE_CYCLES > FIRE_WIDTH) ? SETTLE_CYCLES : FIRE_WIDTH;
   localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] FIRE_LAST   = PW'(FIRE_WIDTH - 1);
   localparam logic [8:0]    MOVES_TGT   = 9'(NUM_MOVES);

   state_t        state, state_nxt;
   logic [PW-1:0] phase;
   logic [2:0]    last_move;
   logic          last_vld;
   logic [2:0]    move_new;
   logic [8:0]    moves_inc;
   logic          gap_end;

   // Bumping a repeat avoids a move that would undo the one just made.
   assign move_new  = (last_vld && rand_in == last_move) ? rand_in + 3'd1 : rand_in;
   assign moves_inc = {1'b0, moves_done} + 9'd1;
   assign gap_end   = (state == GAP) && (phase == SETTLE_LAST);

   always_comb begin
      state_nxt  = state;
      x_nRow     = user_nRow;
      row_column = user_row_column;
      fire       = user_fire;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            busy       = 1'b1;
            x_nRow     = move_new[2];
            row_column = 4'b0001 << move_new[1:0];
            fire       = 1'b0;
            state_nxt  = SETUP;
         end
         SETUP, FIRE, GAP: begin
            busy       = 1'b1;
            x_nRow     = last_move[2];
            row_column = 4'b0001 << last_move[1:0];
            fire       = (state == FIRE);
            if (state == SETUP && phase == SETTLE_LAST) state_nxt = FIRE;
            if (state == FIRE && phase == FIRE_LAST)    state_nxt = GAP;
            if (gap_end) state_nxt = (moves_inc >= MOVES_TGT) ? DONE : LOAD;
         end
         DONE: begin
            done      = 1'b1;
            fire      = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort gates fire combinationally so a pulse in flight is cut short.
      if (busy && abort) begin
         fire      = 1'b0;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         phase      <= '0;
         moves_done <= 8'd0;
         last_move  <= 3'd0;
         last_vld   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            phase <= '0;
         else if (busy)
            phase <= phase + 1'b1;
         if (state == IDLE && start) begin
            moves_done <= 8'd0;
            last_vld   <= 1'b0;
         end
         if (state == LOAD && !abort) begin
            last_move <= move_new;
            last_vld  <= 1'b1;
         end
         if (gap_end && !abort && ({1'b0, moves_done} < MOVES_TGT))
            moves_done <= moves_inc[7:0];
      end
   end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Randomized bench for scramble_sequencer: a move-schedule reference model predicts every output each cycle.
module tb_scramble_sequencer;

   localparam int NUM_MOVES = 16;
   localparam int SETTLE    = 4;
   localparam int FIRE_W    = 1;
   localparam int MOVE_LEN  = 1 + 2 * SETTLE + FIRE_W;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [2:0] rand_in;
   logic       user_nRow, user_fire;
   logic [3:0] user_row_column;
   logic       x_nRow, fire, busy, done;
   logic [3:0] row_column;
   logic [7:0] moves_done;

   always #5 clk = ~clk;

   scramble_sequencer #(.NUM_MOVES(NUM_MOVES), .SETTLE_CYCLES(SETTLE), .FIRE_WIDTH(FIRE_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .rand_in(rand_in),
      .user_nRow(user_nRow), .user_row_column(user_row_column), .user_fire(user_fire),
      .x_nRow(x_nRow), .row_column(row_column), .fire(fire), .busy(busy), .done(done),
      .moves_done(moves_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a scramble is a run of fixed-length moves counted from the first busy cycle.
   bit m_active, m_done_pend, m_last_vld;
   int m_rel, m_cnt, m_cur, m_last;
   int fix_rand = -1;

   int cyc, done_at, busy_cnt;
   int fire_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit st, input bit ab, input bit rs);
      int p, m, e_x, e_rc, e_f, e_b, e_d;
      @(posedge clk);
      #1;
      start = st; abort = ab; reset = rs;
      rand_in = (fix_rand >= 0) ? 3'(fix_rand) : 3'($urandom);
      user_nRow = 1'($urandom);
      user_row_column = 4'($urandom);
      user_fire = 1'($urandom);
      p = m_rel % MOVE_LEN;
      m = m_cur;
      e_x = user_nRow; e_rc = user_row_column; e_f = user_fire; e_b = 0; e_d = 0;
      if (m_active) begin
         if (p == 0) begin
            m = rand_in;
            if (m_last_vld && m == m_last) m = (m + 1) % 8;
         end
         e_x  = m / 4;
         e_rc = 1 << (m % 4);
         e_f  = (p >= 1 + SETTLE && p < 1 + SETTLE + FIRE_W && !ab) ? 1 : 0;
         e_b  = 1;
      end else if (m_done_pend) begin
         e_f = 0;
         e_d = 1;
      end
      #3;
      check("x_nRow", x_nRow, e_x);
      check("row_column", row_column, e_rc);
      check("fire", fire, e_f);
      check("busy", busy, e_b);
      check("done", done, e_d);
      check("moves_done", moves_done, m_cnt);
      cyc++;
      if (fire === 1'b1 && busy === 1'b1) fire_cyc.push_back(cyc);
      if (done === 1'b1) done_at = cyc;
      if (busy === 1'b1) busy_cnt++;
      if (rs) begin
         m_active = 0; m_done_pend = 0; m_cnt = 0; m_last_vld = 0;
      end else if (m_active) begin
         if (ab) m_active = 0;
         else begin
            if (p == 0) begin m_cur = m; m_last = m; m_last_vld = 1; end
            if (p == MOVE_LEN - 1) begin
               m_cnt++;
               if (m_cnt == NUM_MOVES) begin m_active = 0; m_done_pend = 1; end
            end
            m_rel++;
         end
      end else if (m_done_pend) begin
         m_done_pend = 0;
      end else if (st) begin
         m_active = 1; m_rel = 0; m_cnt = 0; m_last_vld = 0;
      end
   endtask

   task automatic clear_stats();
      cyc = -1; done_at = -1; busy_cnt = 0;
      fire_cyc.delete();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; rand_in = 3'd0;
      user_nRow = 1'b0; user_row_column = 4'd0; user_fire = 1'b0;
      m_active = 0; m_done_pend = 0; m_last_vld = 0;
      m_rel = 0; m_cnt = 0; m_cur = 0; m_last = 0;
      clear_stats();
      repeat (2) @(posedge clk);
      step(0, 0, 1);
      step(0, 0, 0);

      // Idle pass-through with a fixed user pattern
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b1; reset = 1'b0;
      user_nRow = 1'b1; user_row_column = 4'b0100; user_fire = 1'b1;
      #3;
      check("idle_x_nRow", x_nRow, 1);
      check("idle_row_column", row_column, 4'b0100);
      check("idle_fire", fire, 1);
      check("idle_busy", busy, 0);
      check("idle_moves_done", moves_done, 0);

      // Full undisturbed scramble with random moves and noisy user inputs
      clear_stats();
      step(1, 0, 0);
      repeat (NUM_MOVES * MOVE_LEN + 3) step(0, 0, 0);
      check("full_fire_count", fire_cyc.size(), NUM_MOVES);
      if (fire_cyc.size() > 0) check("full_first_fire", fire_cyc[0], 1 + 1 + SETTLE);
      for (int i = 1; i < fire_cyc.size(); i++)
         check("full_fire_spacing", fire_cyc[i] - fire_cyc[i-1], MOVE_LEN);
      check("full_busy_cycles", busy_cnt, NUM_MOVES * MOVE_LEN);
      check("full_done_cycle", done_at, NUM_MOVES * MOVE_LEN + 1);
      check("full_moves_done", moves_done, NUM_MOVES);

      // Constant random source: moves must alternate 011 / 100
      fix_rand = 3;
      clear_stats();
      step(1, 0, 0);
      step(0, 0, 0);
      check("const_move1_rc", row_column, 4'b1000);
      check("const_move1_nrow", x_nRow, 0);
      repeat (MOVE_LEN) step(0, 0, 0);
      check("const_move2_rc", row_column, 4'b0001);
      check("const_move2_nrow", x_nRow, 1);
      repeat (NUM_MOVES * MOVE_LEN) step(0, 0, 0);
      fix_rand = -1;

      // Abort in the fire cycle of move 5
      clear_stats();
      step(1, 0, 0);
      repeat (4 * MOVE_LEN + 1 + SETTLE) step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      check("abort_busy", busy, 0);
      check("abort_moves_done", moves_done, 4);
      repeat (3) step(0, 0, 0);
      check("abort_no_done", done_at, -1);
      clear_stats();
      step(1, 0, 0);
      repeat (NUM_MOVES * MOVE_LEN + 2) step(0, 0, 0);
      check("after_abort_fires", fire_cyc.size(), NUM_MOVES);
      check("after_abort_moves", moves_done, NUM_MOVES);

      // Reset in the GAP of move 3, then start pulses during busy and on DONE
      step(1, 0, 0);
      repeat (2 * MOVE_LEN + 1 + SETTLE + FIRE_W + 1) step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      check("rst_busy", busy, 0);
      check("rst_moves_done", moves_done, 0);
      clear_stats();
      step(1, 0, 0);
      while (m_active || m_done_pend) step(m_done_pend ? 1'b1 : ($urandom_range(0, 3) == 0), 0, 0);
      repeat (3) step(0, 0, 0);
      check("nostart_fires", fire_cyc.size(), NUM_MOVES);
      check("nostart_done_cycle", done_at, NUM_MOVES * MOVE_LEN + 1);

      // Random soak
      repeat (3000) step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                         $urandom_range(0, 499) == 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
